// File: rtl/store_merge_unit.sv
// Store merge unit: SD is written directly; SW/SH/SB are read-modify-write against a 64-bit little-endian memory.
// Optional misaligned-store trap is enabled by defining STORE_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module store_merge_unit #(
    parameter int ADDR_W       = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        tam,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    localparam logic [1:0] TAM_SD  = 2'b00;
    localparam logic [1:0] TAM_SW  = 2'b01;
    localparam logic [1:0] TAM_SH  = 2'b10;
    localparam logic [1:0] TAM_SB  = 2'b11;
    localparam logic [2:0] RL_INIT = 3'(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        tam_q, tam_d;
    logic [2:0]        off_q, off_d;
    logic [63:0]       sdata_q, sdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic              mem_wr_q, mem_wr_d;
    logic              misalign_s;

    // Byte offset forced to the natural alignment of the store size.
    function automatic logic [2:0] lane_offset(input logic [1:0] size, input logic [2:0] a);
        logic [2:0] off;
        case (size)
            TAM_SW:  off = {a[2], 2'b00};
            TAM_SH:  off = {a[2:1], 1'b0};
            TAM_SB:  off = a;
            default: off = 3'b000;
        endcase
        return off;
    endfunction

    function automatic logic [63:0] merge_lanes(input logic [63:0] old_v, input logic [63:0] new_v,
                                                input logic [1:0] size, input logic [2:0] off);
        logic [63:0] res;
        logic [3:0]  nbytes;
        logic [3:0]  lane;
        logic [3:0]  rel;
        res = old_v;
        case (size)
            TAM_SW:  nbytes = 4'd4;
            TAM_SH:  nbytes = 4'd2;
            TAM_SB:  nbytes = 4'd1;
            default: nbytes = 4'd8;
        endcase
        for (int i = 0; i < 8; i++) begin
            lane = 4'(i);
            rel  = lane - {1'b0, off};
            if ((lane >= {1'b0, off}) && (rel < nbytes)) begin
                res[8*i +: 8] = new_v[{rel[2:0], 3'b000} +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef STORE_MISALIGN_TRAP_EN
    // Flag stores whose address is not naturally aligned for their size.
    always_comb begin
        case (tam)
            TAM_SD:  misalign_s = (addr[2:0] != 3'b000);
            TAM_SW:  misalign_s = (addr[1:0] != 2'b00);
            TAM_SH:  misalign_s = addr[0];
            default: misalign_s = 1'b0;
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state and next-output computation for the store FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tam_d       = tam_q;
        off_d       = off_q;
        sdata_d     = sdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mis_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tam_d      = tam;
                    off_d      = addr[2:0];
                    sdata_d    = wdata;
                    mem_addr_d = {addr[ADDR_W-1:3], 3'b000};
                    if (misalign_s) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                    end else if (tam == TAM_SD) begin
                        state_d     = WRITE;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = READ;
                        cnt_d   = RL_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (cnt_q == 3'd1) begin
                    mem_wdata_d = merge_lanes(mem_rdata, sdata_q, tam_q, lane_offset(tam_q, off_q));
                    cnt_d       = 3'd0;
                    state_d     = WRITE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        mem_wr_d = (state_d == WRITE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            tam_q       <= 2'b00;
            off_q       <= 3'd0;
            sdata_q     <= 64'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 64'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tam_q       <= tam_d;
            off_q       <= off_d;
            sdata_q     <= sdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = mis_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: one instance at READ_LATENCY=1 and one at READ_LATENCY=3.
// Expectations follow STORE_MISALIGN_TRAP_EN when it is defined.
`timescale 1ns/1ps
module tb_store_merge_unit;

    localparam logic [63:0] INIT   = 64'h1122334455667788;
    localparam logic [63:0] POISON = 64'hBAD0BAD0BAD0BAD0;

    logic        clk = 1'b0;
    logic        reset, start, start3;
    logic [1:0]  tam;
    logic [63:0] addr, wdata;
    logic        busy, done, misaligned, mem_wr;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy3, done3, misaligned3, mem_wr3;
    logic [63:0] mem_addr3, mem_wdata3, mem_rdata3;

    logic [63:0] mem1 [0:31];
    logic [63:0] mem3 [0:31];
    logic        pre_en, pre_sel;
    logic [4:0]  pre_idx;
    logic [63:0] pre_val;
    int          n_vec = 0, n_err = 0;
    int          wr3_total = 0, done3_total = 0, age3 = 0;
    int          wr_base, dn_base;

    store_merge_unit #(.ADDR_W(64), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .tam(tam), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .misaligned(misaligned), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    store_merge_unit #(.ADDR_W(64), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .tam(tam), .addr(addr), .wdata(wdata),
        .busy(busy3), .done(done3), .misaligned(misaligned3), .mem_addr(mem_addr3),
        .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3));

    always #5 clk = ~clk;

    assign mem_rdata  = mem1[mem_addr[7:3]];
    assign mem_rdata3 = (age3 >= 2) ? mem3[mem_addr3[7:3]] : POISON;

    always @(posedge clk) begin
        if (pre_en && !pre_sel) mem1[pre_idx] <= pre_val;
        else if (mem_wr)        mem1[mem_addr[7:3]] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (pre_en && pre_sel) mem3[pre_idx] <= pre_val;
        else if (mem_wr3)      mem3[mem_addr3[7:3]] <= mem_wdata3;
        if (mem_wr3) wr3_total   <= wr3_total + 1;
        if (done3)   done3_total <= done3_total + 1;
        age3 <= busy3 ? age3 + 1 : 0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic sel, input logic [4:0] idx, input logic [63:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_sel = sel; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic run_store(input logic sel3, input logic [1:0] t, input logic [63:0] a,
                             input logic [63:0] d, input int exp_wr_n, input logic [63:0] exp_maddr,
                             input logic [63:0] exp_data, input int exp_wr_cyc, input int exp_dn_cyc,
                             input logic exp_mis, input string tag);
        int          wr_n, wr_c, dn_n, dn_c;
        logic [63:0] wa, wd;
        logic        mis_seen;
        wr_n = 0; wr_c = 0; dn_n = 0; dn_c = 0; wa = 64'd0; wd = 64'd0; mis_seen = 1'b0;
        @(negedge clk);
        tam = t; addr = a; wdata = d; start = !sel3; start3 = sel3;
        @(negedge clk);
        start = 1'b0; start3 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) chk({tag, "/busy_c1"}, 64'(sel3 ? busy3 : busy), 64'd1);
            if (sel3 ? mem_wr3 : mem_wr) begin
                wr_n++; wr_c = c;
                wa = sel3 ? mem_addr3 : mem_addr;
                wd = sel3 ? mem_wdata3 : mem_wdata;
            end
            if (sel3 ? done3 : done) begin
                dn_n++; dn_c = c;
                mis_seen = sel3 ? misaligned3 : misaligned;
            end
            @(negedge clk);
        end
        chk({tag, "/wr_count"}, 64'(wr_n), 64'(exp_wr_n));
        if (exp_wr_n == 1) begin
            chk({tag, "/wr_cycle"}, 64'(wr_c), 64'(exp_wr_cyc));
            chk({tag, "/wr_addr"}, wa, exp_maddr);
            chk({tag, "/wr_data"}, wd, exp_data);
        end
        chk({tag, "/done_count"}, 64'(dn_n), 64'd1);
        chk({tag, "/done_cycle"}, 64'(dn_c), 64'(exp_dn_cyc));
        chk({tag, "/misaligned"}, 64'(mis_seen), 64'(exp_mis));
        chk({tag, "/idle_after"}, 64'(sel3 ? busy3 : busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start3 = 1'b0; tam = 2'b00; addr = 64'd0; wdata = 64'd0;
        pre_en = 1'b0; pre_sel = 1'b0; pre_idx = 5'd0; pre_val = 64'd0;
        for (int i = 0; i < 32; i++) begin
            poke(1'b0, 5'(i), 64'd0);
            poke(1'b1, 5'(i), 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/done", 64'(done), 64'd0);
        chk("rst/misaligned", 64'(misaligned), 64'd0);
        chk("rst/mem_wr", 64'(mem_wr), 64'd0);
        chk("rst/mem_addr", mem_addr, 64'd0);
        chk("rst/mem_wdata", mem_wdata, 64'd0);
        chk("rst/busy3", 64'(busy3), 64'd0);

        poke(1'b0, 5'd2, INIT);
        run_store(1'b0, 2'b11, 64'h13, 64'hAB, 1, 64'h10, 64'h11223344AB667788, 2, 3, 1'b0, "sb_off3");
        chk("sb_off3/mem", mem1[2], 64'h11223344AB667788);
        poke(1'b0, 5'd2, INIT);
        run_store(1'b0, 2'b10, 64'h16, 64'hBEEF, 1, 64'h10, 64'hBEEF334455667788, 2, 3, 1'b0, "sh_off6");
        poke(1'b0, 5'd2, INIT);
        run_store(1'b0, 2'b01, 64'h14, 64'hDEADBEEF, 1, 64'h10, 64'hDEADBEEF55667788, 2, 3, 1'b0, "sw_off4");
        run_store(1'b0, 2'b00, 64'h18, 64'h0123456789ABCDEF, 1, 64'h18, 64'h0123456789ABCDEF, 1, 2, 1'b0, "sd");
        chk("sd/mem", mem1[3], 64'h0123456789ABCDEF);
        poke(1'b0, 5'd2, INIT);
        run_store(1'b0, 2'b11, 64'h10, 64'hFFFFFFFFFFFFFF5A, 1, 64'h10, 64'h112233445566775A, 2, 3, 1'b0, "sb_off0");
        poke(1'b0, 5'd2, INIT);
        run_store(1'b0, 2'b11, 64'h17, 64'h99, 1, 64'h10, 64'h9922334455667788, 2, 3, 1'b0, "sb_off7");
        poke(1'b0, 5'd31, 64'hA5A5A5A5A5A5A5A5);
        run_store(1'b0, 2'b10, 64'hFFFFFFFFFFFFFFFE, 64'h1234, 1, 64'hFFFFFFFFFFFFFFF8,
                  64'h1234A5A5A5A5A5A5, 2, 3, 1'b0, "sh_top");

        poke(1'b0, 5'd2, INIT);
        poke(1'b0, 5'd3, 64'h0);
`ifdef STORE_MISALIGN_TRAP_EN
        run_store(1'b0, 2'b01, 64'h12, 64'hCAFEBABE, 0, 64'h0, 64'h0, 0, 1, 1'b1, "sw_mis");
        chk("sw_mis/mem", mem1[2], INIT);
        run_store(1'b0, 2'b00, 64'h19, 64'h0F0E0D0C0B0A0908, 0, 64'h0, 64'h0, 0, 1, 1'b1, "sd_mis");
        chk("sd_mis/mem", mem1[3], 64'h0);
`else
        run_store(1'b0, 2'b01, 64'h12, 64'hCAFEBABE, 1, 64'h10, 64'h11223344CAFEBABE, 2, 3, 1'b0, "sw_mis");
        chk("sw_mis/mem", mem1[2], 64'h11223344CAFEBABE);
        run_store(1'b0, 2'b00, 64'h19, 64'h0F0E0D0C0B0A0908, 1, 64'h18, 64'h0F0E0D0C0B0A0908, 1, 2, 1'b0, "sd_mis");
        chk("sd_mis/mem", mem1[3], 64'h0F0E0D0C0B0A0908);
`endif

        poke(1'b1, 5'd2, INIT);
        run_store(1'b1, 2'b11, 64'h13, 64'hAB, 1, 64'h10, 64'h11223344AB667788, 4, 5, 1'b0, "sb_rl3");

        // Reset while the latency-3 instance is in READ.
        poke(1'b1, 5'd2, INIT);
        wr_base = wr3_total;
        @(negedge clk);
        tam = 2'b11; addr = 64'h10; wdata = 64'h77; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("rst_rd/busy_before", 64'(busy3), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rd/busy", 64'(busy3), 64'd0);
        chk("rst_rd/mem_wr", 64'(mem_wr3), 64'd0);
        chk("rst_rd/done", 64'(done3), 64'd0);
        chk("rst_rd/mem_addr", mem_addr3, 64'd0);
        chk("rst_rd/mem_wdata", mem_wdata3, 64'd0);
        repeat (6) @(negedge clk);
        chk("rst_rd/no_write", 64'(wr3_total - wr_base), 64'd0);
        chk("rst_rd/mem", mem3[2], INIT);
        run_store(1'b1, 2'b00, 64'h20, 64'hFEDCBA9876543210, 1, 64'h20, 64'hFEDCBA9876543210, 1, 2, 1'b0, "sd_after_rst");
        chk("sd_after_rst/mem", mem3[4], 64'hFEDCBA9876543210);

        // start held for six edges: only one store, then a new one accepted in the following IDLE cycle.
        wr_base = wr3_total;
        dn_base = done3_total;
        @(negedge clk);
        tam = 2'b11; addr = 64'h15; wdata = 64'h3C; start3 = 1'b1;
        repeat (6) @(negedge clk);
        chk("hold/idle", 64'(busy3), 64'd0);
        chk("hold/wr_count", 64'(wr3_total - wr_base), 64'd1);
        chk("hold/done_count", 64'(done3_total - dn_base), 64'd1);
        chk("hold/mem", mem3[2], 64'h11223C4455667788);
        tam = 2'b00; addr = 64'h28; wdata = 64'h5555AAAA;
        @(negedge clk);
        start3 = 1'b0;
        chk("next/busy", 64'(busy3), 64'd1);
        chk("next/mem_wr", 64'(mem_wr3), 64'd1);
        chk("next/mem_addr", mem_addr3, 64'h28);
        repeat (3) @(negedge clk);
        chk("next/mem", mem3[5], 64'h5555AAAA);
        chk("next/idle", 64'(busy3), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
